// File: rtl/clic_preempt_stack.sv
// CLIC preemption controller: accepts the arbiter's winning candidate when it outranks the
// running context, saves that context on a nesting stack and restores it on handler return.
module clic_preempt_stack #(
   parameter int NR_PRIO_BITS  = 3,
   parameter int NR_INDEX_BITS = 2,
   parameter int STACK_DEPTH   = 2**NR_PRIO_BITS - 1,
   localparam int DEPTH_W      = $clog2(STACK_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   input  logic [NR_INDEX_BITS-1:0] req_index,
   input  logic [NR_PRIO_BITS-1:0]  req_prio,
   output logic                     take,
   input  logic                     ret,
   output logic                     cur_valid,
   output logic [NR_INDEX_BITS-1:0] cur_index,
   output logic [NR_PRIO_BITS-1:0]  cur_prio,
   output logic                     dispatch,
   output logic [NR_INDEX_BITS-1:0] dispatch_index,
   output logic [DEPTH_W-1:0]       depth,
   output logic                     err_overflow,
   output logic                     err_underflow
);

   localparam int CTX_W = 1 + NR_INDEX_BITS + NR_PRIO_BITS;
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

   typedef enum logic {THREAD = 1'b0, HANDLER = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic [NR_INDEX_BITS-1:0] index_q, index_d;
   logic [NR_PRIO_BITS-1:0]  prio_q, prio_d;
   logic [DEPTH_W-1:0]       depth_q, depth_d, top_idx;
   logic                     vld_p1, vld_d;
   logic [NR_INDEX_BITS-1:0] dispatch_index_p1, dispatch_index_d;
   logic                     ovf_q, ovf_d, unf_q, unf_d;
   logic                     push;
   logic [CTX_W-1:0]         pop_ctx;
   logic [CTX_W-1:0]         stack_q [STACK_DEPTH];

   assign top_idx = depth_q - DEPTH_W'(1);
   assign pop_ctx = stack_q[top_idx];

   // ret has priority over a new candidate; the candidate is re-evaluated next cycle
   assign take = req_valid && !ret && (req_prio > prio_q) && (depth_q < DEPTH_MAX);

   always_comb begin
      state_d          = state_q;
      index_d          = index_q;
      prio_d           = prio_q;
      depth_d          = depth_q;
      vld_d            = 1'b0;
      dispatch_index_d = '0;
      ovf_d            = ovf_q;
      unf_d            = unf_q;
      push             = 1'b0;

      if (ret) begin
         if (state_q == HANDLER) begin
            if (depth_q != '0) begin
               state_d = pop_ctx[CTX_W-1] ? HANDLER : THREAD;
               index_d = pop_ctx[NR_PRIO_BITS +: NR_INDEX_BITS];
               prio_d  = pop_ctx[NR_PRIO_BITS-1:0];
               depth_d = top_idx;
            end else begin
               state_d = THREAD;
               index_d = '0;
               prio_d  = '0;
            end
         end else begin
            unf_d = 1'b1;
         end
      end else if (take) begin
         push             = 1'b1;
         state_d          = HANDLER;
         index_d          = req_index;
         prio_d           = req_prio;
         depth_d          = depth_q + DEPTH_W'(1);
         vld_d            = 1'b1;
         dispatch_index_d = req_index;
      end

      if (req_valid && (req_prio > prio_q) && (depth_q == DEPTH_MAX))
         ovf_d = 1'b1;
   end

   // stage p1: context, depth, errors and the dispatch pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q           <= THREAD;
         index_q           <= '0;
         prio_q            <= '0;
         depth_q           <= '0;
         vld_p1            <= 1'b0;
         dispatch_index_p1 <= '0;
         ovf_q             <= 1'b0;
         unf_q             <= 1'b0;
      end else begin
         state_q           <= state_d;
         index_q           <= index_d;
         prio_q            <= prio_d;
         depth_q           <= depth_d;
         vld_p1            <= vld_d;
         dispatch_index_p1 <= dispatch_index_d;
         ovf_q             <= ovf_d;
         unf_q             <= unf_d;
      end
   end

   // Saved contexts carry no reset; only slots below depth are ever read.
   always_ff @(posedge clk) begin
      if (push)
         stack_q[depth_q] <= {state_q == HANDLER, index_q, prio_q};
   end

   assign cur_valid      = (state_q == HANDLER);
   assign cur_index      = index_q;
   assign cur_prio       = prio_q;
   assign depth          = depth_q;
   assign dispatch       = vld_p1;
   assign dispatch_index = dispatch_index_p1;
   assign err_overflow   = ovf_q;
   assign err_underflow  = unf_q;

endmodule

// File: tb/tb_clic_preempt_stack.sv
// Randomized and directed bench for clic_preempt_stack: a full-depth and a depth-2 instance
// share stimulus and are each compared against a context/stack reference model.
module tb_clic_preempt_stack;

   logic       clk = 1'b0;
   logic       rst_n, req_valid, ret;
   logic [1:0] req_index;
   logic [2:0] req_prio;

   logic       a_take, a_cur_valid, a_dispatch, a_ovf, a_unf;
   logic [1:0] a_cur_index, a_dispatch_index;
   logic [2:0] a_cur_prio, a_depth;
   logic       b_take, b_cur_valid, b_dispatch, b_ovf, b_unf;
   logic [1:0] b_cur_index, b_dispatch_index;
   logic [2:0] b_cur_prio;
   logic [1:0] b_depth;

   always #5 clk = ~clk;

   clic_preempt_stack dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_index(req_index),
      .req_prio(req_prio), .take(a_take), .ret(ret), .cur_valid(a_cur_valid),
      .cur_index(a_cur_index), .cur_prio(a_cur_prio), .dispatch(a_dispatch),
      .dispatch_index(a_dispatch_index), .depth(a_depth), .err_overflow(a_ovf),
      .err_underflow(a_unf));

   clic_preempt_stack #(.STACK_DEPTH(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_index(req_index),
      .req_prio(req_prio), .take(b_take), .ret(ret), .cur_valid(b_cur_valid),
      .cur_index(b_cur_index), .cur_prio(b_cur_prio), .dispatch(b_dispatch),
      .dispatch_index(b_dispatch_index), .depth(b_depth), .err_overflow(b_ovf),
      .err_underflow(b_unf));

   typedef struct {bit v; int idx; int prio;} ctx_t;

   ctx_t m_cur [2];
   ctx_t m_stk [2][8];
   int   m_dep [2];
   int   m_max [2];
   bit   m_ovf [2], m_unf [2], m_disp [2];
   int   m_didx [2];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      m_cur[k]  = '{0, 0, 0};
      m_dep[k]  = 0;
      m_ovf[k]  = 0;
      m_unf[k]  = 0;
      m_disp[k] = 0;
      m_didx[k] = 0;
   endtask

   task automatic check_outputs(input int k);
      string p;
      p = (k == 0) ? "a." : "b.";
      check({p, "cur_valid"}, (k == 0) ? int'(a_cur_valid) : int'(b_cur_valid), int'(m_cur[k].v));
      check({p, "cur_index"}, (k == 0) ? int'(a_cur_index) : int'(b_cur_index), m_cur[k].idx);
      check({p, "cur_prio"},  (k == 0) ? int'(a_cur_prio)  : int'(b_cur_prio),  m_cur[k].prio);
      check({p, "depth"},     (k == 0) ? int'(a_depth)     : int'(b_depth),     m_dep[k]);
      check({p, "dispatch"},  (k == 0) ? int'(a_dispatch)  : int'(b_dispatch),  int'(m_disp[k]));
      if (m_disp[k])
         check({p, "dispatch_index"},
               (k == 0) ? int'(a_dispatch_index) : int'(b_dispatch_index), m_didx[k]);
      check({p, "err_overflow"},  (k == 0) ? int'(a_ovf) : int'(b_ovf), int'(m_ovf[k]));
      check({p, "err_underflow"}, (k == 0) ? int'(a_unf) : int'(b_unf), int'(m_unf[k]));
   endtask

   // One clock cycle: apply inputs, check take, advance the model, check registered outputs.
   task automatic cycle(input bit rn, input bit rv, input int ri, input int rp, input bit rt);
      bit exp_take [2];
      rst_n     = rn;
      req_valid = rv;
      req_index = ri[1:0];
      req_prio  = rp[2:0];
      ret       = rt;
      #1;
      for (int k = 0; k < 2; k++) begin
         exp_take[k] = rv && !rt && (rp > m_cur[k].prio) && (m_dep[k] < m_max[k]);
         check((k == 0) ? "a.take" : "b.take",
               (k == 0) ? int'(a_take) : int'(b_take), int'(exp_take[k]));
      end
      for (int k = 0; k < 2; k++) begin
         if (!rn) begin
            model_reset(k);
         end else begin
            m_disp[k] = 0;
            if (rv && (rp > m_cur[k].prio) && (m_dep[k] == m_max[k]))
               m_ovf[k] = 1;
            if (rt) begin
               if (m_cur[k].v) begin
                  if (m_dep[k] > 0) begin
                     m_dep[k]--;
                     m_cur[k] = m_stk[k][m_dep[k]];
                  end else begin
                     m_cur[k] = '{0, 0, 0};
                  end
               end else begin
                  m_unf[k] = 1;
               end
            end else if (exp_take[k]) begin
               m_stk[k][m_dep[k]] = m_cur[k];
               m_dep[k]++;
               m_cur[k]  = '{1, ri, rp};
               m_disp[k] = 1;
               m_didx[k] = ri;
            end
         end
      end
      @(posedge clk);
      #2;
      check_outputs(0);
      check_outputs(1);
   endtask

   initial begin
      m_max[0] = 7;
      m_max[1] = 2;
      rst_n = 1'b0; req_valid = 1'b0; req_index = '0; req_prio = '0; ret = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      model_reset(0);
      model_reset(1);
      check_outputs(0);
      check_outputs(1);

      // idle, then ret in thread mode
      repeat (5) cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1);
      check("a.underflow_set", int'(a_unf), 1);

      // single preempt and return
      cycle(1, 1, 2, 3, 0);
      check("a.first_dispatch_index", int'(a_dispatch_index), 2);
      cycle(1, 0, 0, 0, 1);

      // nesting, equal priority rejected, restore
      cycle(1, 1, 2, 3, 0);
      cycle(1, 1, 1, 5, 0);
      cycle(1, 1, 0, 5, 0);
      cycle(1, 0, 0, 0, 1);
      check("a.restored_prio", int'(a_cur_prio), 3);
      check("a.restored_index", int'(a_cur_index), 2);
      cycle(1, 0, 0, 0, 1);

      // tail-chain with one bubble
      cycle(1, 1, 1, 4, 0);
      cycle(1, 1, 3, 2, 1);
      cycle(1, 1, 3, 2, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1);

      // fill the stack with priorities 1..7
      for (int p = 1; p <= 7; p++) cycle(1, 1, p % 4, p, 0);
      check("a.full_depth", int'(a_depth), 7);
      check("a.full_prio", int'(a_cur_prio), 7);
      check("b.overflow_set", int'(b_ovf), 1);
      check("b.full_depth", int'(b_depth), 2);
      cycle(1, 1, 0, 3, 0);
      for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 1);

      // reset in the cycle after take
      cycle(0, 0, 0, 0, 0);
      cycle(1, 1, 2, 6, 0);
      cycle(0, 0, 0, 0, 0);
      check("a.reset_dispatch", int'(a_dispatch), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               $urandom_range(0, 3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
